// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time of an asynchronous PWM input.
//
// The input is synchronized (2 flops), optionally glitch-filtered, and
// edge-detected (1 flop). A free-running counter restarts at 1 on every
// rise. The high time is captured on the fall. The period is captured on the
// next rise, which completes a sample. The first rise after idle, reset or
// timeout only starts a measurement and never produces a sample.
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a glitch filter.
// The filtered level follows the synchronized input only after the input has
// held a new value for FILT_LEN consecutive cycles. Without the macro, edges
// are acted on 3 cycles after the input transition and FILT_LEN is unused.
//
// Parameters:
//   WIDTH    width of the counters and of PERIOD/HIGH
//   TIMEOUT  cycles without an edge before STUCK is raised
//   FILT_LEN glitch-filter stability length (filter build only)
// Ports:
//   CLK      system clock, rising edge
//   RST      asynchronous active-high reset
//   PWM_IN   asynchronous PWM input
//   ACK      one-cycle pulse that consumes the held sample
//   PERIOD   rise-to-rise time of the last sample, in CLK cycles
//   HIGH     rise-to-fall time of the last sample, in CLK cycles
//   VALID    a sample is held and not yet acknowledged
//   OVERRUN  sticky: a sample completed while VALID was set
//   STUCK    no edge seen for TIMEOUT cycles
//   LEVEL    synchronized (and filtered) input level
module pwm_capture #(
  parameter int unsigned       WIDTH    = 28,
  parameter logic [WIDTH-1:0]  TIMEOUT  = 28'd50_000_000,
  parameter int unsigned       FILT_LEN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  input  logic             ACK,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             STUCK,
  output logic             LEVEL
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  // Parameter sanity: a zero timeout or zero-length filter is meaningless.
  if (FILT_LEN < 1 || TIMEOUT == '0) begin : g_bad_params
    $error("pwm_capture: FILT_LEN and TIMEOUT must both be at least 1");
  end

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             lvl_prev;
  logic             armed;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             timeout;
  logic             complete;
  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] idle_cnt;
  logic [WIDTH-1:0] high_shadow;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others (sync2 gets the old sync1).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FW     = $clog2(FILT_LEN + 1);
  localparam int unsigned SETTLE = 3 + FILT_LEN;

  logic          filt;
  logic [FW-1:0] filt_cnt;

  // Count consecutive cycles on which the synchronized input disagrees with
  // the filtered level; adopt the new value on the FILT_LEN-th such cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt     <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  localparam int unsigned SETTLE = 3;

  assign lvl = sync2;
`endif

  // After reset the pipeline holds zeros, not the real input. If PWM_IN is
  // already high, the first real level would look like a rise in the middle
  // of a pulse. Edges are ignored until the pipeline and lvl_prev have been
  // filled from the live input, so a partial pulse is never measured.
  localparam int unsigned SW = $clog2(SETTLE + 1);
  logic [SW-1:0] settle_cnt;

  assign armed = (settle_cnt == SW'(SETTLE));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      settle_cnt <= '0;
      lvl_prev   <= 1'b0;
    end else begin
      lvl_prev <= lvl;
      if (!armed) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign rise     = armed &  lvl & ~lvl_prev;
  assign fall     = armed & ~lvl &  lvl_prev;
  assign any_edge = rise | fall;
  assign timeout  = !any_edge && (idle_cnt == TIMEOUT - 1'b1);
  assign complete = (state == MEAS_LOW) && rise;
  assign LEVEL    = lvl;

  // Measurement counter: 1 on the cycle of a rise, saturating otherwise.
  // Cycles since the last edge: parks at TIMEOUT so the timeout fires once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      if (rise)            cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (cnt != '1)  cnt <= cnt + 1'b1;

      if (any_edge)                idle_cnt <= '0;
      else if (idle_cnt != TIMEOUT) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      high_shadow <= '0;
      PERIOD      <= '0;
      HIGH        <= '0;
      VALID       <= 1'b0;
      OVERRUN     <= 1'b0;
      STUCK       <= 1'b0;
    end else if (timeout) begin
      state  <= IDLE;
      STUCK  <= 1'b1;
      PERIOD <= '0;
      HIGH   <= '0;
      VALID  <= 1'b0;
      if (ACK) OVERRUN <= 1'b0;
    end else begin
      if (any_edge) STUCK <= 1'b0;

      case (state)
        IDLE:      if (rise) state <= MEAS_HIGH;
        MEAS_HIGH: if (fall) begin
                     high_shadow <= cnt;
                     state       <= MEAS_LOW;
                   end
        MEAS_LOW:  if (rise) state <= MEAS_HIGH;
        default:   state <= IDLE;
      endcase

      // A completing sample wins over ACK; an unacknowledged one overruns.
      if (complete) begin
        PERIOD <= cnt;
        HIGH   <= high_shadow;
        VALID  <= 1'b1;
        if (VALID && !ACK) OVERRUN <= 1'b1;
      end else if (ACK) begin
        VALID   <= 1'b0;
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- self-checking bench for pwm_capture.
// The reference model works at the level of whole PWM cycles: each driven
// rise completes a sample built from the previous high/low durations when a
// measurement is already running; ACK and timeout update the expectations.
module tb_pwm_capture;

  localparam int unsigned      WIDTH    = 28;
  localparam logic [WIDTH-1:0] TIMEOUT  = 28'd1000;
  localparam int unsigned      FILT_LEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             PWM_IN;
  logic             ACK;
  logic [WIDTH-1:0] PERIOD;
  logic [WIDTH-1:0] HIGH;
  logic             VALID;
  logic             OVERRUN;
  logic             STUCK;
  logic             LEVEL;

  pwm_capture #(
    .WIDTH    (WIDTH),
    .TIMEOUT  (TIMEOUT),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PWM_IN  (PWM_IN),
    .ACK     (ACK),
    .PERIOD  (PERIOD),
    .HIGH    (HIGH),
    .VALID   (VALID),
    .OVERRUN (OVERRUN),
    .STUCK   (STUCK),
    .LEVEL   (LEVEL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit exp_valid;
  bit exp_ovr;
  bit exp_stuck;
  int exp_period;
  int exp_high;
  bit have_rise;
  int prev_h;
  int prev_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_ovr    = 1'b0;
    exp_stuck  = 1'b0;
    exp_period = 0;
    exp_high   = 0;
    have_rise  = 1'b0;
  endtask

  // A rise has been registered; ack_now means ACK was high on that cycle.
  task automatic model_rise(input int h, input int l, input bit ack_now);
    exp_stuck = 1'b0;
    if (have_rise) begin
      if (exp_valid && !ack_now) exp_ovr = 1'b1;
      exp_valid  = 1'b1;
      exp_period = prev_h + prev_l;
      exp_high   = prev_h;
    end else if (ack_now) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
    have_rise = 1'b1;
    prev_h    = h;
    prev_l    = l;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"},   VALID,   exp_valid);
    check({tag, "_overrun"}, OVERRUN, exp_ovr);
    check({tag, "_period"},  PERIOD,  exp_period);
    check({tag, "_high"},    HIGH,    exp_high);
    check({tag, "_stuck"},   STUCK,   exp_stuck);
  endtask

  // One PWM cycle: h cycles high then l cycles low.
  // ack_mode: 0 none, 1 ACK mid low phase, 2 ACK on the cycle the rise lands.
  task automatic drive_cycle(input int h, input int l, input int ack_mode);
    PWM_IN = 1'b1;
    if (ack_mode == 2) begin
      tick(LAT - 1);
      ACK = 1'b1;
      tick(1);
      ACK = 1'b0;
      tick(h - LAT);
    end else begin
      tick(h);
    end
    model_rise(h, l, ack_mode == 2);
    check_outputs("rise");
    check("rise_level", LEVEL, 1);
    PWM_IN = 1'b0;
    if (ack_mode == 1) begin
      tick(l / 2);
      ACK = 1'b1;
      tick(1);
      ACK = 1'b0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      check_outputs("ack");
      tick(l - l / 2 - 1);
    end else begin
      tick(l);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST    = 1'b1;
    PWM_IN = 1'b0;
    ACK    = 1'b0;
    model_reset();
    tick(3);
    check_outputs("reset");
    check("reset_level", LEVEL, 0);
    RST = 1'b0;
    tick(5);

    // Steady 100/25: discard, sample, overrun, then ACK clears.
    drive_cycle(25, 75, 0);
    drive_cycle(25, 75, 0);
    drive_cycle(25, 75, 0);
    drive_cycle(25, 75, 1);

    // ACK coinciding with completion: new 80/30 sample loaded, VALID kept.
    drive_cycle(30, 50, 0);
    drive_cycle(40, 60, 2);

    // Randomized cycles and ACK placement.
    for (int i = 0; i < 20; i++) begin
      drive_cycle(int'($urandom_range(10, 150)), int'($urandom_range(10, 150)),
                  int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a high phase.
    PWM_IN = 1'b1;
    tick(20);
    RST = 1'b1;
    tick(2);
    model_reset();
    check_outputs("midrst");
    check("midrst_level", LEVEL, 0);
    RST = 1'b0;
    tick(30);
    PWM_IN = 1'b0;
    tick(60);
    check_outputs("postrst");
    drive_cycle(35, 65, 0);
    drive_cycle(35, 65, 0);

`ifdef PWM_CAPTURE_FILTER_EN
    begin
      bit seen;
      RST = 1'b1;
      tick(2);
      RST = 1'b0;
      model_reset();
      tick(20);
      // 2-cycle glitch must not reach LEVEL.
      seen = 1'b0;
      PWM_IN = 1'b1;
      for (int i = 0; i < 2; i++) begin tick(1); seen |= LEVEL; end
      PWM_IN = 1'b0;
      for (int i = 0; i < 15; i++) begin tick(1); seen |= LEVEL; end
      check("glitch_level", seen, 0);
      check_outputs("glitch");
      // 5-cycle pulse is a real rise+fall; it starts a measurement.
      seen = 1'b0;
      PWM_IN = 1'b1;
      for (int i = 0; i < 5; i++) begin tick(1); seen |= LEVEL; end
      PWM_IN = 1'b0;
      for (int i = 0; i < 15; i++) begin tick(1); seen |= LEVEL; end
      check("pulse_level", seen, 1);
      tick(40);
      have_rise = 1'b1;
      prev_h    = 5;
      prev_l    = 55;
      drive_cycle(40, 60, 0);
    end
`endif

    // Timeout with the input held high after valid samples.
    drive_cycle(40, 60, 1);
    PWM_IN = 1'b1;
    tick(LAT);
    model_rise(0, 0, 1'b0);
    check_outputs("hold");
    tick(int'(TIMEOUT) - 1);
    check("stuck_early", STUCK, 0);
    tick(1);
    exp_stuck  = 1'b1;
    exp_valid  = 1'b0;
    exp_period = 0;
    exp_high   = 0;
    have_rise  = 1'b0;
    check_outputs("timeout");
    PWM_IN = 1'b0;
    tick(LAT);
    exp_stuck = 1'b0;
    check("stuck_clear", STUCK, 0);
    tick(40);
    drive_cycle(30, 70, 0);
    drive_cycle(30, 70, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 28, bit width of the measurement counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 28'd50_000_000, the number of CLK cycles without a detected edge before the block declares the input stuck.
REQ-003 SHALL have parameter FILT_LEN, default 4, the number of CLK cycles of glitch-filter stability (used only when the Configuration macro is defined).
REQ-004 SHALL have one clock and an asynchronous active-high reset, with the ports listed below.
- CLK  input  1  system clock; all state on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- PWM_IN  input  1  asynchronous PWM signal to be measured.
- ACK  input  1  single-cycle pulse from the CPU PIO that consumes the current sample.
- PERIOD  output  WIDTH  CLK cycles from one rising edge to the next.
- HIGH  output  WIDTH  CLK cycles from a rising edge to the following falling edge.
- VALID  output  1  a new PERIOD/HIGH pair is held and not yet acknowledged.
- OVERRUN  output  1  a sample completed while VALID=1; sticky.
- STUCK  output  1  no edge for TIMEOUT cycles.
- LEVEL  output  1  current synchronized (and filtered) input level.

Function
REQ-005 SHALL pass PWM_IN through a 2-flop synchronizer, followed by a 1-flop edge detector; a detected edge SHALL be registered 3 CLK cycles after the input transition is sampled.
REQ-006 SHALL implement the states IDLE, MEAS_HIGH and MEAS_LOW.
- IDLE -> MEAS_HIGH on a detected rise.
- MEAS_HIGH -> MEAS_LOW on a detected fall.
- MEAS_LOW -> MEAS_HIGH on a detected rise, which completes a sample.
- Any state -> IDLE on timeout.
REQ-007 SHALL clear the counter to 1 on each rise; it SHALL increment every cycle otherwise, saturating at all-ones with no wrap-around.
REQ-008 SHALL capture the counter value into the HIGH shadow on the fall in MEAS_HIGH.
REQ-009 SHALL, on a rise in MEAS_LOW, load PERIOD from the counter and HIGH from the shadow, and set VALID in the next cycle.
REQ-010 SHALL discard the first rise out of IDLE; no sample is produced until a full high-plus-low cycle has been measured.
REQ-011 SHALL clear VALID on ACK; PERIOD and HIGH SHALL hold their values until the next sample is loaded.
REQ-012 SHALL, if a sample completes while VALID=1, overwrite PERIOD/HIGH, keep VALID=1 and set OVERRUN; OVERRUN SHALL clear only on ACK or RST.
REQ-013 SHALL give the new sample priority when ACK and sample completion coincide: load the outputs, keep VALID=1 and leave OVERRUN unchanged.
REQ-014 SHALL, when the idle-edge counter reaches TIMEOUT, set STUCK, zero PERIOD and HIGH, clear VALID and enter IDLE.
REQ-015 SHALL clear STUCK on the next detected edge.
REQ-016 SHALL treat a 100% or 0% duty-cycle input as a timeout; this is the required behaviour, not an error.

Reset
REQ-017 SHALL, while RST=1, force:
- PERIOD=0, HIGH=0, VALID=0, OVERRUN=0, STUCK=0, LEVEL=0;
- the state machine to IDLE;
- synchronizer flops, counters and filter to 0.
REQ-018 SHALL abandon any partial measurement on reset asserted mid-operation; after release, the first sample SHALL follow REQ-010.

Configuration
REQ-019 SHALL, with PWM_CAPTURE_FILTER_EN defined, insert a glitch filter after the synchronizer: the filtered level changes only after the synchronized input has held the new value for FILT_LEN consecutive cycles, which adds FILT_LEN cycles of latency to every edge.
REQ-020 SHALL, without PWM_CAPTURE_FILTER_EN, omit the filter entirely; FILT_LEN SHALL then be unused and the edge latency SHALL be exactly 3 cycles.

Verification
REQ-021 SHALL cover a steady input with period 100 CLK and high time 25 CLK -> after the second rise, VALID=1, PERIOD=100, HIGH=25, OVERRUN=0.
REQ-022 SHALL cover three periods of the REQ-021 input without ACK -> OVERRUN=1, VALID=1 and PERIOD=100; then one ACK -> VALID=0, OVERRUN=0, PERIOD still 100.
REQ-023 SHALL cover TIMEOUT=1000 with PWM_IN held at 1 after valid samples -> STUCK=1 at 1000 cycles after the last edge, PERIOD=0, HIGH=0, VALID=0; the next toggles restart measurement and clear STUCK.
REQ-024 SHALL cover RST pulsed mid-high-phase -> all outputs 0; the first post-reset sample is reported only after one full period, with correct values.
REQ-025 SHALL cover ACK asserted in the same cycle as sample completion -> VALID stays 1 and the new PERIOD/HIGH are loaded.
REQ-026 SHALL cover, with PWM_CAPTURE_FILTER_EN and FILT_LEN=4, a 2-cycle glitch on a low input -> no state change and no sample; a 5-cycle pulse -> detected as an edge.
